// File: rtl/hilo_muldiv_seq_pkg.sv
// rtl/hilo_muldiv_seq_pkg.sv - shared types and helpers for the HI/LO mul/div sequencer
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } seq_state_e;

    // Divides live in the upper half of the opcode space
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[1];
    endfunction

    // The unsigned variants are the odd opcodes
    function automatic logic is_signed_op(input muldiv_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// rtl/hilo_muldiv_seq_if.sv - EX-stage request / HI-LO result bundle
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_EX;
    logic [1:0]       op_EX;
    logic [WIDTH-1:0] src_a_EX;
    logic [WIDTH-1:0] src_b_EX;
    logic             rd_hilo_EX;
    logic             busy;
    logic             stall_EX;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EX-stage control unit side
    modport master (
        output start_EX, op_EX, src_a_EX, src_b_EX, rd_hilo_EX,
        input  busy, stall_EX, done, hi, lo
    );

    // Sequencer side
    modport slave (
        input  start_EX, op_EX, src_a_EX, src_b_EX, rd_hilo_EX,
        output busy, stall_EX, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_seq_step_core.sv
// rtl/hilo_muldiv_seq_step_core.sv - one combinational shift-add or restoring-divide iteration
module hilo_step_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_low,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_low
);
    // Multiply: acc never exceeds WIDTH bits between steps, so the sum fits in WIDTH+1
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    // Divide: partial remainder shifted left with the next dividend bit, then trial-subtracted
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_sum   = i_acc + {1'b0, i_opnd};
    assign w_add   = i_low[0] ? w_sum : i_acc;
    assign w_shift = {i_acc[WIDTH-1:0], i_low[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_opnd};

    // Select the iteration; a clear borrow bit means the divisor fit and the quotient bit is 1
    always_comb begin
        o_acc = i_acc;
        o_low = i_low;
        if (i_is_div) begin
            if (!w_diff[WIDTH+1]) begin
                o_acc = w_diff[WIDTH:0];
                o_low = {i_low[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shift;
                o_low = {i_low[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {1'b0, w_add[WIDTH:1]};
            o_low = {w_add[0], i_low[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - iterative mul/div sequencer owning the HI/LO register pair
module hilo_muldiv_seq
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    seq_state_e       r_state;
    muldiv_op_e       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_res;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;

    muldiv_op_e         w_op;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_low_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Operand magnitudes and signs are taken straight from EX at acceptance
    assign w_op     = muldiv_op_e'(bus.op_EX);
    assign w_signed = is_signed_op(w_op);
    assign w_a_neg  = w_signed & bus.src_a_EX[WIDTH-1];
    assign w_b_neg  = w_signed & bus.src_b_EX[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.src_a_EX : bus.src_a_EX;
    assign w_b_mag  = w_b_neg ? -bus.src_b_EX : bus.src_b_EX;

    // Final sign correction applied in the FIX cycle
    assign w_prod     = {r_acc[WIDTH-1:0], r_low};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_rem      = r_acc[WIDTH-1:0];
    assign w_q_fix    = r_neg_q ? -r_low : r_low;
    assign w_r_fix    = r_neg_r ? -w_rem : w_rem;

    hilo_step_core #(.WIDTH(WIDTH)) u_step (
        .i_is_div (is_div_op(r_op)),
        .i_acc    (r_acc),
        .i_low    (r_low),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_nxt),
        .o_low    (w_low_nxt)
    );

    // Sequencer FSM: accept in IDLE, iterate WIDTH times in RUN, sign-fix and commit HI/LO in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= MD_MULT;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_low     <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_EX) begin
                        r_op      <= w_op;
                        r_acc     <= '0;
                        r_opnd    <= is_div_op(w_op) ? w_b_mag : w_a_mag;
                        r_low     <= is_div_op(w_op) ? w_a_mag : w_b_mag;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        // A zero divisor leaves the quotient as all ones regardless of sign
                        r_neg_q   <= (w_a_neg ^ w_b_neg) & (bus.src_b_EX != '0);
                        r_neg_r   <= w_a_neg;
                        r_cnt     <= CW'(WIDTH - 1);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_low <= w_low_nxt;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (is_div_op(r_op)) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.stall_EX = r_busy & (bus.start_EX | bus.rd_hilo_EX);
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - directed self-checking bench for hilo_muldiv_seq
module tb_hilo_muldiv_seq;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    hilo_muldiv_seq_if #(.WIDTH(32)) bus ();

    hilo_muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op in cycle 0 and check latency, hold behaviour, result and pulse width
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        bus.start_EX = 1'b1;
        bus.op_EX    = op;
        bus.src_a_EX = a;
        bus.src_b_EX = b;
        tick();
        cyc = 1;
        bus.start_EX = 1'b0;
        chk({tag, "_busy_c1"}, {31'b0, bus.busy}, 32'd1);
        while (!bus.done && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 33) chk({tag, "_hi_hold_c33"}, bus.hi, prev_hi);
        end
        chk({tag, "_latency"}, cyc, 32'd34);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
        prev_hi = ehi;
        prev_lo = elo;
        tick();
        chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n_done;
        n_tests = 0;
        n_fail  = 0;
        prev_hi = 32'h0;
        prev_lo = 32'h0;
        rst            = 1'b1;
        bus.start_EX   = 1'b0;
        bus.op_EX      = 2'b00;
        bus.src_a_EX   = 32'h0;
        bus.src_b_EX   = 32'h0;
        bus.rd_hilo_EX = 1'b1;

        // Reset held two cycles with mfhi pending
        tick();
        tick();
        chk("rst_hi",    bus.hi, 32'h0);
        chk("rst_lo",    bus.lo, 32'h0);
        chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
        chk("rst_done",  {31'b0, bus.done}, 32'd0);
        chk("rst_stall", {31'b0, bus.stall_EX}, 32'd0);
        rst            = 1'b0;
        bus.rd_hilo_EX = 1'b0;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_min",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Stall behaviour: mfhi from cycle 5, a second op held from cycle 10
        bus.start_EX = 1'b1;
        bus.op_EX    = 2'b00;
        bus.src_a_EX = 32'd5;
        bus.src_b_EX = 32'd6;
        tick();
        bus.start_EX = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        bus.rd_hilo_EX = 1'b1;
        #1;
        chk("stall_c5", {31'b0, bus.stall_EX}, 32'd1);
        for (int c = 6; c <= 33; c++) begin
            tick();
            if (c == 10) begin
                bus.start_EX = 1'b1;
                bus.op_EX    = 2'b01;
                bus.src_a_EX = 32'h0001_0001;
                bus.src_b_EX = 32'h0003_0000;
                #1;
            end
            chk($sformatf("stall_c%0d", c), {31'b0, bus.stall_EX}, 32'd1);
        end
        tick();
        chk("stall_c34", {31'b0, bus.stall_EX}, 32'd0);
        chk("done_c34",  {31'b0, bus.done}, 32'd1);
        chk("hi_c34",    bus.hi, 32'h0000_0000);
        chk("lo_c34",    bus.lo, 32'h0000_001E);
        tick();
        bus.start_EX   = 1'b0;
        bus.rd_hilo_EX = 1'b0;
        chk("second_accepted", {31'b0, bus.busy}, 32'd1);
        cyc = 35;
        while (!bus.done && cyc < 80) begin
            tick();
            cyc++;
        end
        chk("second_done_cycle", cyc, 32'd68);
        chk("second_hi", bus.hi, 32'h0000_0003);
        chk("second_lo", bus.lo, 32'h0003_0000);
        tick();

        // Reset in the middle of a divu
        bus.start_EX = 1'b1;
        bus.op_EX    = 2'b11;
        bus.src_a_EX = 32'd100;
        bus.src_b_EX = 32'd7;
        tick();
        bus.start_EX = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_hi",   bus.hi, 32'h0);
        chk("midrst_lo",   bus.lo, 32'h0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.done) n_done++;
        end
        chk("midrst_no_done", n_done, 32'd0);
        prev_hi = 32'h0;
        prev_lo = 32'h0;

        run_op("multu_after", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
